// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// One request is outstanding at a time; the slave answers with a single-cycle mem_ack.
interface memory_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues LOAD/STORE on the data-memory bus and stalls upstream until the access completes.
// Optional MEM_TIMEOUT_EN adds an ACCESS watchdog of TIMEOUT cycles and a sticky o_mem_err flag.
module memory_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    i_control_in,
  input  logic [15:0]   i_result_in,
  input  logic [15:0]   i_store_data_in,
  input  logic [4:0]    i_dest_index_in,
  output logic          o_stall,
  output logic [15:0]   o_wb_data,
  output logic [4:0]    o_wb_dest,
  output logic [4:0]    o_wb_control,
  output logic          o_wb_en,
  output logic          o_mem_err,
  memory_stage_if.master mem
);

  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_ADDI  = 4'h3;
  localparam logic [3:0] OP_SHLLI = 4'h4;
  localparam logic [3:0] OP_SHRLI = 4'h5;
  localparam logic [3:0] OP_LOAD  = 4'hC;
  localparam logic [3:0] OP_LOADI = 4'hD;
  localparam logic [3:0] OP_STORE = 4'hE;
  localparam logic [3:0] OP_MOV   = 4'hF;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      r_state, w_next_state;
  logic [15:0] r_mem_addr, r_mem_wdata;
  logic        r_mem_we;
  logic [4:0]  r_dest, r_control;
  logic [15:0] r_wb_data;
  logic [4:0]  r_wb_dest, r_wb_control;
  logic        r_wb_en;

  logic [3:0]  w_op;
  logic        w_is_mem, w_ack, w_abort, w_latch, w_leave, w_pass_en;
  logic [15:0] w_wb_data;
  logic [4:0]  w_wb_dest, w_wb_control;
  logic        w_wb_en;

  assign w_op     = i_control_in[3:0];
  assign w_is_mem = (w_op == OP_LOAD) || (w_op == OP_STORE);
  assign w_ack    = (r_state == ACCESS) && mem.mem_ack;

  always_comb begin
    case (w_op)
      OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI, OP_LOADI, OP_MOV: w_pass_en = 1'b1;
      default:                                                       w_pass_en = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    o_stall      = 1'b0;
    w_latch      = 1'b0;
    w_leave      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_is_mem) begin
          o_stall      = 1'b1;
          w_latch      = 1'b1;
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (w_ack || w_abort) begin
          w_leave      = 1'b1;
          w_next_state = IDLE;
        end else begin
          o_stall = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A stalled cycle or an aborted access writes back a NOP bubble (the defaults).
  always_comb begin
    w_wb_data    = '0;
    w_wb_dest    = '0;
    w_wb_control = '0;
    w_wb_en      = 1'b0;
    if (!o_stall) begin
      if (r_state == ACCESS) begin
        if (w_ack) begin
          w_wb_dest    = r_dest;
          w_wb_control = r_control;
          if (r_control[3:0] == OP_LOAD) begin
            w_wb_data = mem.mem_rdata;
            w_wb_en   = 1'b1;
          end
        end
      end else begin
        w_wb_data    = i_result_in;
        w_wb_dest    = i_dest_index_in;
        w_wb_control = i_control_in;
        w_wb_en      = w_pass_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_dest      <= '0;
      r_control   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_mem_addr  <= i_result_in;
        r_mem_wdata <= i_store_data_in;
        r_mem_we    <= (w_op == OP_STORE);
        r_dest      <= i_dest_index_in;
        r_control   <= i_control_in;
      end else if (w_leave) begin
        r_mem_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_data    <= '0;
      r_wb_dest    <= '0;
      r_wb_control <= '0;
      r_wb_en      <= 1'b0;
    end else begin
      r_wb_data    <= w_wb_data;
      r_wb_dest    <= w_wb_dest;
      r_wb_control <= w_wb_control;
      r_wb_en      <= w_wb_en;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_mem_err;

  // Abort on the cycle that would bring the no-ack count up to TIMEOUT.
  assign w_abort = (r_state == ACCESS) && !mem.mem_ack && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (w_latch) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == ACCESS) && !mem.mem_ack) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_abort) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign o_mem_err = r_mem_err;
`else
  assign w_abort   = 1'b0;
  assign o_mem_err = 1'b0;
`endif

  assign mem.mem_req   = (r_state == ACCESS);
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

  assign o_wb_data    = r_wb_data;
  assign o_wb_dest    = r_wb_dest;
  assign o_wb_control = r_wb_control;
  assign o_wb_en      = r_wb_en;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: pass-through vector table plus hand-written memory-access sequences.
// The timeout sequence is selected when MEM_TIMEOUT_EN is defined, otherwise an unbounded-wait sequence runs.
module tb_memory_stage;

  logic        clk;
  logic        rst_n;
  logic [4:0]  controlIn;
  logic [15:0] resultIn;
  logic [15:0] storeDataIn;
  logic [4:0]  destIndexIn;
  logic        stall;
  logic [15:0] wbData;
  logic [4:0]  wbDest;
  logic [4:0]  wbControl;
  logic        wbEn;
  logic        memErr;

  int total = 0;
  int bad   = 0;

  memory_stage_if mif ();

  memory_stage #(.TIMEOUT(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_control_in    (controlIn),
    .i_result_in     (resultIn),
    .i_store_data_in (storeDataIn),
    .i_dest_index_in (destIndexIn),
    .o_stall         (stall),
    .o_wb_data       (wbData),
    .o_wb_dest       (wbDest),
    .o_wb_control    (wbControl),
    .o_wb_en         (wbEn),
    .o_mem_err       (memErr),
    .mem             (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctrl;
    logic [15:0] res;
    logic [15:0] sdata;
    logic [4:0]  dest;
    logic        ack;
    logic [15:0] rdata;
    logic [15:0] expData;
    logic [4:0]  expDest;
    logic [4:0]  expCtrl;
    logic        expEn;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] ctrl, input logic [15:0] res, input logic [15:0] sdata,
                               input logic [4:0] dest, input logic ack, input logic [15:0] rdata);
    controlIn     = ctrl;
    resultIn      = res;
    storeDataIn   = sdata;
    destIndexIn   = dest;
    mif.mem_ack   = ack;
    mif.mem_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBubble(input string name);
    checkOutput({name, " wb_en"}, wbEn, 1'b0);
    checkOutput({name, " wb_data"}, wbData, 16'h0000);
    checkOutput({name, " wb_control"}, wbControl, 5'h00);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{5'h02, 16'h1234, 16'h0000, 5'd3,  1'b0, 16'h0000, 16'h1234, 5'd3,  5'h02, 1'b1};
    vecs[1]  = '{5'h01, 16'hFFFF, 16'h0001, 5'd7,  1'b0, 16'h0000, 16'hFFFF, 5'd7,  5'h01, 1'b1};
    vecs[2]  = '{5'h0B, 16'h5555, 16'h0000, 5'd4,  1'b0, 16'h0000, 16'h5555, 5'd4,  5'h0B, 1'b0};
    vecs[3]  = '{5'h06, 16'h0100, 16'h0000, 5'd0,  1'b0, 16'h0000, 16'h0100, 5'd0,  5'h06, 1'b0};
    vecs[4]  = '{5'h0D, 16'h00FF, 16'h0000, 5'd31, 1'b0, 16'h0000, 16'h00FF, 5'd31, 5'h0D, 1'b1};
    vecs[5]  = '{5'h1F, 16'hABCD, 16'h0000, 5'd9,  1'b0, 16'h0000, 16'hABCD, 5'd9,  5'h1F, 1'b1};
    vecs[6]  = '{5'h10, 16'h7777, 16'h0000, 5'd2,  1'b0, 16'h0000, 16'h7777, 5'd2,  5'h10, 1'b0};
    vecs[7]  = '{5'h03, 16'h0042, 16'h0000, 5'd12, 1'b1, 16'hDEAD, 16'h0042, 5'd12, 5'h03, 1'b1};
    vecs[8]  = '{5'h05, 16'h8001, 16'h0000, 5'd1,  1'b0, 16'h0000, 16'h8001, 5'd1,  5'h05, 1'b1};
    vecs[9]  = '{5'h0A, 16'h0F0F, 16'h0000, 5'd6,  1'b0, 16'h0000, 16'h0F0F, 5'd6,  5'h0A, 1'b0};
    vecs[10] = '{5'h04, 16'h2468, 16'h0000, 5'd8,  1'b0, 16'h0000, 16'h2468, 5'd8,  5'h04, 1'b1};
    vecs[11] = '{5'h08, 16'h1357, 16'h0000, 5'd10, 1'b0, 16'h0000, 16'h1357, 5'd10, 5'h08, 1'b0};

    rst_n = 1'b0;
    applyStimulus(5'h00, 16'h0000, 16'h0000, 5'd0, 1'b0, 16'h0000);
    #12;
    checkOutput("reset mem_req", mif.mem_req, 1'b0);
    checkOutput("reset mem_we", mif.mem_we, 1'b0);
    checkOutput("reset mem_addr", mif.mem_addr, 16'h0000);
    checkOutput("reset mem_wdata", mif.mem_wdata, 16'h0000);
    checkOutput("reset wb_data", wbData, 16'h0000);
    checkOutput("reset wb_dest", wbDest, 5'd0);
    checkOutput("reset wb_control", wbControl, 5'h00);
    checkOutput("reset wb_en", wbEn, 1'b0);
    checkOutput("reset mem_err", memErr, 1'b0);
    checkOutput("reset stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Pass-through table: one cycle latency, never stalls.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].res, vecs[i].sdata, vecs[i].dest, vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
      checkOutput($sformatf("vec%0d stall", i), stall, 1'b0);
      checkOutput($sformatf("vec%0d mem_req", i), mif.mem_req, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d wb_data", i), wbData, vecs[i].expData);
      checkOutput($sformatf("vec%0d wb_dest", i), wbDest, vecs[i].expDest);
      checkOutput($sformatf("vec%0d wb_control", i), wbControl, vecs[i].expCtrl);
      checkOutput($sformatf("vec%0d wb_en", i), wbEn, vecs[i].expEn);
    end

    // LOAD acknowledged in its first ACCESS cycle.
    applyStimulus(5'h0C, 16'h0040, 16'h1111, 5'd5, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("load req-cycle stall", stall, 1'b1);
    checkOutput("load req-cycle mem_req", mif.mem_req, 1'b0);
    tick();
    checkBubble("load bubble");
    checkOutput("load mem_req", mif.mem_req, 1'b1);
    checkOutput("load mem_addr", mif.mem_addr, 16'h0040);
    checkOutput("load mem_we", mif.mem_we, 1'b0);
    applyStimulus(5'h0C, 16'h0040, 16'h1111, 5'd5, 1'b1, 16'hBEEF);
    @(negedge clk);
    checkOutput("load ack stall", stall, 1'b0);
    tick();
    checkOutput("load wb_data", wbData, 16'hBEEF);
    checkOutput("load wb_dest", wbDest, 5'd5);
    checkOutput("load wb_control", wbControl, 5'h0C);
    checkOutput("load wb_en", wbEn, 1'b1);
    checkOutput("load mem_req after", mif.mem_req, 1'b0);
    applyStimulus(5'h00, 16'h0000, 16'h0000, 5'd0, 1'b0, 16'h0000);
    tick();

    // STORE acknowledged in the third ACCESS cycle.
    applyStimulus(5'h0E, 16'h0010, 16'h00AA, 5'd1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("store req-cycle stall", stall, 1'b1);
    tick();
    for (int k = 1; k <= 3; k++) begin
      checkOutput($sformatf("store c%0d mem_req", k), mif.mem_req, 1'b1);
      checkOutput($sformatf("store c%0d mem_we", k), mif.mem_we, 1'b1);
      checkOutput($sformatf("store c%0d mem_addr", k), mif.mem_addr, 16'h0010);
      checkOutput($sformatf("store c%0d mem_wdata", k), mif.mem_wdata, 16'h00AA);
      checkBubble($sformatf("store c%0d bubble", k));
      if (k == 3) mif.mem_ack = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("store c%0d stall", k), stall, (k == 3) ? 1'b0 : 1'b1);
      tick();
    end
    checkOutput("store wb_en", wbEn, 1'b0);
    checkOutput("store wb_data", wbData, 16'h0000);
    checkOutput("store mem_req after", mif.mem_req, 1'b0);
    checkOutput("store mem_we after", mif.mem_we, 1'b0);

    // CMP, STORE, LOAD back to back.
    applyStimulus(5'h0B, 16'h0003, 16'h0000, 5'd2, 1'b0, 16'h0000);
    tick();
    checkOutput("b2b cmp wb_en", wbEn, 1'b0);
    checkOutput("b2b cmp wb_data", wbData, 16'h0003);
    applyStimulus(5'h0E, 16'h0020, 16'h5A5A, 5'd0, 1'b0, 16'h0000);
    tick();
    checkOutput("b2b store mem_req", mif.mem_req, 1'b1);
    mif.mem_ack = 1'b1;
    tick();
    applyStimulus(5'h0C, 16'h0020, 16'h0000, 5'd11, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("b2b idle gap mem_req", mif.mem_req, 1'b0);
    checkOutput("b2b load stall", stall, 1'b1);
    tick();
    checkOutput("b2b load mem_req", mif.mem_req, 1'b1);
    checkOutput("b2b load mem_we", mif.mem_we, 1'b0);
    applyStimulus(5'h0C, 16'h0020, 16'h0000, 5'd11, 1'b1, 16'h4321);
    tick();
    checkOutput("b2b load wb_data", wbData, 16'h4321);
    checkOutput("b2b load wb_dest", wbDest, 5'd11);
    checkOutput("b2b load wb_en", wbEn, 1'b1);
    applyStimulus(5'h00, 16'h0000, 16'h0000, 5'd0, 1'b0, 16'h0000);
    tick();
    checkOutput("b2b load written once", wbEn, 1'b0);

    // Asynchronous reset in the middle of an ACCESS.
    applyStimulus(5'h0C, 16'h0080, 16'h2222, 5'd6, 1'b0, 16'h0000);
    tick();
    checkOutput("rst pre mem_req", mif.mem_req, 1'b1);
    checkOutput("rst pre mem_addr", mif.mem_addr, 16'h0080);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async mem_req", mif.mem_req, 1'b0);
    checkOutput("rst async mem_addr", mif.mem_addr, 16'h0000);
    checkOutput("rst async mem_wdata", mif.mem_wdata, 16'h0000);
    applyStimulus(5'h00, 16'h0000, 16'h0000, 5'd0, 1'b1, 16'hBAD0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rst post mem_req", mif.mem_req, 1'b0);
    checkOutput("rst post wb_en", wbEn, 1'b0);
    checkOutput("rst post wb_data", wbData, 16'h0000);
    mif.mem_ack = 1'b0;

    // Asynchronous reset clears a live writeback.
    applyStimulus(5'h02, 16'h00C3, 16'h0000, 5'd4, 1'b0, 16'h0000);
    tick();
    checkOutput("rst2 pre wb_en", wbEn, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst2 async wb_en", wbEn, 1'b0);
    checkOutput("rst2 async wb_data", wbData, 16'h0000);
    checkOutput("rst2 async wb_dest", wbDest, 5'd0);
    applyStimulus(5'h00, 16'h0000, 16'h0000, 5'd0, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef MEM_TIMEOUT_EN
    // No ack: abort in the 16th ACCESS cycle, sticky error.
    applyStimulus(5'h0C, 16'h0100, 16'h0000, 5'd7, 1'b0, 16'h0000);
    tick();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tmo c%0d stall", k), stall, (k < 16) ? 1'b1 : 1'b0);
      checkOutput($sformatf("tmo c%0d mem_err", k), memErr, 1'b0);
      tick();
    end
    checkOutput("tmo mem_req", mif.mem_req, 1'b0);
    checkOutput("tmo mem_err", memErr, 1'b1);
    checkBubble("tmo bubble");
    applyStimulus(5'h02, 16'h0001, 16'h0000, 5'd1, 1'b0, 16'h0000);
    tick();
    checkOutput("tmo sticky mem_err", memErr, 1'b1);
    checkOutput("tmo next wb_en", wbEn, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("tmo reset mem_err", memErr, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`else
    // No ack: access waits indefinitely and no error is raised.
    applyStimulus(5'h0C, 16'h0100, 16'h0000, 5'd7, 1'b0, 16'h0000);
    tick();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1 || k == 16 || k == 20) begin
        checkOutput($sformatf("wait c%0d stall", k), stall, 1'b1);
        checkOutput($sformatf("wait c%0d mem_req", k), mif.mem_req, 1'b1);
        checkOutput($sformatf("wait c%0d mem_err", k), memErr, 1'b0);
      end
      tick();
    end
    applyStimulus(5'h0C, 16'h0100, 16'h0000, 5'd7, 1'b1, 16'h0F00);
    tick();
    checkOutput("wait load wb_data", wbData, 16'h0F00);
    checkOutput("wait load wb_en", wbEn, 1'b1);
    checkOutput("wait mem_err", memErr, 1'b0);
    applyStimulus(5'h00, 16'h0000, 16'h0000, 5'd0, 1'b0, 16'h0000);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, number of ACCESS cycles without mem_ack before abort (used only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 control_in  input  5  opcode from Execute; bits [3:0] decoded; bit 4 passed through unchanged.
REQ-005 result_in  input  16  ALU result from Execute; used as memory address for LOAD/STORE.
REQ-006 store_data_in  input  16  store data from Execute.
REQ-007 dest_index_in  input  5  destination register index from Execute.
REQ-008 stall  output  1  high means upstream must hold control_in, result_in, store_data_in and dest_index_in stable.
REQ-009 mem_req, mem_we  output  1 each  data-memory request and write strobe.
REQ-010 mem_addr, mem_wdata  output  16 each  data-memory address and write data.
REQ-011 mem_rdata  input  16  data-memory read data, valid when mem_ack is high.
REQ-012 mem_ack  input  1  data-memory completion, one cycle per request.
REQ-013 wb_data  output  16  registered writeback data.
REQ-014 wb_dest, wb_control  output  5 each  registered destination index and opcode.
REQ-015 wb_en  output  1  registered register-file write enable.
REQ-016 mem_err  output  1  sticky timeout error flag.

Function
REQ-017 Opcodes: NOP 0000, SUB 0001, ADD 0010, ADDI 0011, SHLLI 0100, SHRLI 0101, JUMP 0110, JUMPL 0111, JUMPG 1000, JUMPE 1001, JUMPNE 1010, CMP 1011, LOAD 1100, LOADI 1101, STORE 1110, MOV 1111.
REQ-018 Memory ops are LOAD and STORE; all other opcodes are pass-through.
REQ-019 FSM states IDLE and ACCESS; reset state IDLE.
REQ-020 IDLE, memory op on control_in: latch result_in to mem_addr, store_data_in to mem_wdata, mem_we = (STORE), dest and opcode internally; go to ACCESS next edge.
REQ-021 ACCESS: mem_req = 1; mem_addr, mem_wdata and mem_we held constant until the mem_ack cycle.
REQ-022 ACCESS with mem_ack = 1: return to IDLE at next edge; mem_req = 0 from that edge.
REQ-023 stall = (IDLE and memory op present) or (ACCESS and not mem_ack); combinational.
REQ-024 With stall low, each edge loads writeback registers.
REQ-025 Pass-through op: wb_data = result_in, wb_dest = dest_index_in, wb_control = control_in.
REQ-026 Pass-through op: wb_en = 1 for SUB, ADD, ADDI, SHLLI, SHRLI, LOADI, MOV; 0 otherwise.
REQ-027 Completing LOAD: wb_data = mem_rdata; wb_dest and wb_control take the latched values; wb_en = 1.
REQ-028 Completing STORE: wb_en = 0, wb_data = 0.
REQ-029 With stall high, each edge loads a bubble: wb_en = 0, wb_control = NOP, wb_data = 0, wb_dest = 0.
REQ-030 Latency: pass-through 1 cycle; memory op minimum 2 cycles (ack in first ACCESS cycle).
REQ-031 mem_ack outside ACCESS is ignored.
REQ-032 Back-to-back memory ops each pass through IDLE; no request overlap.

Reset
REQ-033 rst_n low forces immediately: state IDLE, mem_req = mem_we = 0, mem_addr = mem_wdata = 0, wb_* = 0, mem_err = 0, timeout counter = 0.
REQ-034 Reset during ACCESS abandons the access; no writeback occurs for it.

Configuration
REQ-035 Macro MEM_TIMEOUT_EN defined: a counter clears on ACCESS entry and increments each ACCESS cycle without mem_ack.
REQ-036 When the counter reaches TIMEOUT, the FSM returns to IDLE, stall drops, a bubble is written back, and mem_err is set until reset.
REQ-037 Macro undefined: ACCESS waits indefinitely, no counter is built, and mem_err is tied 0.

Verification
REQ-038 ADD, result_in = 0x1234, dest 3 -> next edge wb_data = 0x1234, wb_dest = 3, wb_en = 1, stall = 0 throughout.
REQ-039 LOAD, addr 0x0040, ack in first ACCESS cycle with rdata 0xBEEF, dest 5 -> stall high 1 cycle (request cycle), mem_req high 1 cycle; then wb_data = 0xBEEF, wb_dest = 5, wb_en = 1.
REQ-040 STORE, addr 0x0010, data 0x00AA, ack after 3 ACCESS cycles -> mem_we = 1; addr and data stable 3 cycles; bubbles during stall; wb_en = 0.
REQ-041 CMP then STORE then LOAD back-to-back -> CMP wb_en = 0; two separate mem_req pulses with IDLE between; LOAD data written back once.
REQ-042 rst_n low during ACCESS -> mem_req and wb_en go 0 without a clock edge; after release, state IDLE.
REQ-043 MEM_TIMEOUT_EN defined, TIMEOUT = 16, no ack -> abort after 16 ACCESS cycles, mem_err = 1, wb_en = 0; mem_err stays 1 until reset.
